main_fsm_decoder: RTL and testbench

Multi-cycle control unit for the RV32I core. Replaces the single-cycle combinational main decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. Memory accesses use a req/ready handshake with a bounded wait. Illegal opcodes and memory timeouts go to a sticky trap state. Sits between the instruction register (opcode_i, funct_3_i) and the shared-memory multi-cycle datapath.

---
 rtl/main_fsm_pkg.sv | 87 ++++++++
 rtl/main_fsm_out_dec.sv | 90 +++++++++
 rtl/main_fsm_decoder.sv | 135 +++++++++++++
 tb/tb_main_fsm_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalr, StJalrJmp, StLui, StAuipc, StTrap
  } state_t;

  localparam logic [2:0] ImmI     = 3'b000;
  localparam logic [2:0] ImmS     = 3'b001;
  localparam logic [2:0] ImmB     = 3'b010;
  localparam logic [2:0] ImmU     = 3'b011;
  localparam logic [2:0] ImmJ     = 3'b100;
  localparam logic [2:0] ImmShamt = 3'b101;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;

  localparam logic [1:0] ResAluOut  = 2'b00;
  localparam logic [1:0] ResRdData  = 2'b01;
  localparam logic [1:0] ResAluRes  = 2'b10;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr_en;
    logic       adr_src;
    logic       ir_wr_en;
    logic       pc_update;
    logic       branch;
    logic       reg_wr_en;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OpLoad, OpStore: return StMemAdr;
      OpReg:           return StExecR;
      OpImm:           return StExecI;
      OpBranch:        return StBranch;
      OpJal:           return StJal;
      OpJalr:          return StJalr;
      OpLui:           return StLui;
      OpAuipc:         return StAuipc;
      default:         return StTrap;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel(input logic [6:0] opcode, input logic [2:0] funct_3);
    case (opcode)
      OpStore:        return ImmS;
      OpBranch:       return ImmB;
      OpLui, OpAuipc: return ImmU;
      OpJal:          return ImmJ;
      OpImm:          return (funct_3 == 3'b001 || funct_3 == 3'b101) ? ImmShamt : ImmI;
      default:        return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm_out_dec.sv
// Combinational state (+ instruction fields, mem ready) to control-bundle decoder.
module main_fsm_out_dec
  import main_fsm_pkg::*;
(
  input  state_t     state_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct_3_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_req = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.ir_wr_en   = 1'b1;
          ctrl_o.pc_update  = 1'b1;
          ctrl_o.alu_src_a  = SrcAPc;
          ctrl_o.alu_src_b  = SrcBFour;
          ctrl_o.alu_op     = AluAdd;
          ctrl_o.result_src = ResAluRes;
        end
      end
      StDecode: begin
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.imm_src   = imm_sel(opcode_i, funct_3_i);
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
      end
      StMemRead: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.adr_src = 1'b1;
      end
      StMemWb: begin
        ctrl_o.result_src = ResRdData;
        ctrl_o.reg_wr_en  = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_wr_en = 1'b1;
        ctrl_o.adr_src   = 1'b1;
      end
      StExecR: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBRs2;
        ctrl_o.alu_op    = AluFunct;
      end
      StExecI: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluFunct;
      end
      StAluWb: ctrl_o.reg_wr_en = 1'b1;
      StBranch: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBRs2;
        ctrl_o.alu_op    = AluBranch;
        ctrl_o.branch    = 1'b1;
      end
      StJal, StJalrJmp: begin
        // Link value old PC + 4 is computed while the target is written to PC.
        ctrl_o.pc_update = 1'b1;
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBFour;
      end
      StJalr: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.imm_src   = ImmI;
      end
      StLui: begin
        ctrl_o.alu_src_a = SrcAZero;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.imm_src   = ImmU;
      end
      StAuipc: begin
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.imm_src   = ImmU;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm_decoder.sv
// Multi-cycle RV32I main control FSM with bounded memory wait and sticky trap.
// Optional retired-instruction counter enabled by MAIN_FSM_PERF_EN.
module main_fsm_decoder
  import main_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct_3_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_wr_en_o,
  output logic             adr_src_o,
  output logic             ir_wr_en_o,
  output logic             pc_update_o,
  output logic             branch_o,
  output logic             reg_wr_en_o,
  output logic [2:0]       imm_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       result_src_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic             mem_wait, timeout;
  ctrl_t            ctrl, ctrl_out;
  logic [CNT_W-1:0] retired_cnt;

  assign mem_wait = (state_q == StFetch || state_q == StMemRead || state_q == StMemWrite)
                    && !mem_ready_i;
  // Ready on the last allowed wait cycle still wins over the timeout.
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wait_d  = '0;
    if (mem_wait && !timeout && MEM_TIMEOUT != 0) wait_d = wait_q + 1'b1;
    if (timeout) begin
      state_d = StTrap;
      cause_d = CauseTimeout;
    end else begin
      case (state_q)
        StFetch:    if (mem_ready_i) state_d = StDecode;
        StDecode: begin
          state_d = decode_next(opcode_i);
          if (state_d == StTrap) cause_d = CauseIllegal;
        end
        StMemAdr:   state_d = (opcode_i == OpLoad) ? StMemRead : StMemWrite;
        StMemRead:  if (mem_ready_i) state_d = StMemWb;
        StMemWrite: if (mem_ready_i) state_d = StFetch;
        StMemWb, StAluWb, StBranch: state_d = StFetch;
        StExecR, StExecI, StJal, StJalrJmp, StLui, StAuipc: state_d = StAluWb;
        StJalr:     state_d = StJalrJmp;
        StTrap:     state_d = StTrap;
        default:    state_d = StTrap;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      wait_q  <= '0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

`ifdef MAIN_FSM_PERF_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (state_d == StFetch && state_q != StFetch) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;
`endif

  main_fsm_out_dec u_out_dec (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .funct_3_i   (funct_3_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    ctrl_out      = ctrl;
    trap_o        = (state_q == StTrap);
    trap_cause_o  = cause_q;
    retired_cnt_o = retired_cnt;
    if (rst_i) begin
      ctrl_out      = '0;
      trap_o        = 1'b0;
      trap_cause_o  = '0;
      retired_cnt_o = '0;
    end
  end

  assign mem_req_o    = ctrl_out.mem_req;
  assign mem_wr_en_o  = ctrl_out.mem_wr_en;
  assign adr_src_o    = ctrl_out.adr_src;
  assign ir_wr_en_o   = ctrl_out.ir_wr_en;
  assign pc_update_o  = ctrl_out.pc_update;
  assign branch_o     = ctrl_out.branch;
  assign reg_wr_en_o  = ctrl_out.reg_wr_en;
  assign imm_src_o    = ctrl_out.imm_src;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign alu_op_o     = ctrl_out.alu_op;
  assign result_src_o = ctrl_out.result_src;

endmodule

// File: tb/tb_main_fsm_decoder.sv
// Directed bench for main_fsm_decoder: per-cycle expected control vectors via a scoreboard.
module tb_main_fsm_decoder;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] opcode_i = 7'd0;
  logic [2:0] funct_3_i = 3'd0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_wr_en_o, adr_src_o, ir_wr_en_o, pc_update_o, branch_o;
  logic       reg_wr_en_o, trap_o;
  logic [2:0] imm_src_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, trap_cause_o;
  logic [3:0] retired_cnt_o;

`ifdef MAIN_FSM_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  main_fsm_decoder #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .opcode_i     (opcode_i),
    .funct_3_i    (funct_3_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_wr_en_o  (mem_wr_en_o),
    .adr_src_o    (adr_src_o),
    .ir_wr_en_o   (ir_wr_en_o),
    .pc_update_o  (pc_update_o),
    .branch_o     (branch_o),
    .reg_wr_en_o  (reg_wr_en_o),
    .imm_src_o    (imm_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .result_src_o (result_src_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o),
    .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {req, wr, adr, ir, pc, br, rw, imm[3], a[2], b[2], op[2], res[2], trap, cause[2]}
  function automatic logic [20:0] mk(input logic req, wr, adr, ir, pc, br, rw,
                                     input logic [2:0] imm, input logic [1:0] a, b, op, res,
                                     input logic tr, input logic [1:0] c);
    return {req, wr, adr, ir, pc, br, rw, imm, a, b, op, res, tr, c};
  endfunction

  function automatic logic [20:0] dec_ev(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, imm, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
  endfunction

  function automatic logic [20:0] trap_ev(input logic [1:0] c);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, c);
  endfunction

  localparam logic [20:0] E_ZERO = 21'd0;
  localparam logic [20:0] E_FW   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0,
                                      2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_FR   = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0,
                                      2'd2, 2'd0, 2'd2, 1'b0, 2'd0);
  localparam logic [20:0] E_MADR = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2,
                                      2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_MRD  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0,
                                      2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_MWB  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0,
                                      2'd0, 2'd0, 2'd1, 1'b0, 2'd0);
  localparam logic [20:0] E_MWR  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0,
                                      2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_EXR  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2,
                                      2'd0, 2'd2, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_EXI  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2,
                                      2'd1, 2'd2, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_AWB  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0,
                                      2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_BR   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2,
                                      2'd0, 2'd1, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_JMP  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1,
                                      2'd2, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_JALR = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2,
                                      2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_LUI  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd3,
                                      2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [20:0] E_AUI  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd1,
                                      2'd1, 2'd0, 2'd0, 1'b0, 2'd0);

  typedef struct {
    string       tag;
    logic [20:0] vec;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_asrt = 0;
  int          n_fail = 0;
  logic [3:0]  exp_cnt = 4'd0;
  logic [20:0] obs;

  assign obs = {mem_req_o, mem_wr_en_o, adr_src_o, ir_wr_en_o, pc_update_o, branch_o,
                reg_wr_en_o, imm_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
                trap_o, trap_cause_o};

  always @(negedge clk_i) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_asrt++;
      assert (obs === e.vec) else begin
        n_fail++;
        $error("FAIL %s ctrl: got %h expected %h", e.tag, obs, e.vec);
      end
      n_asrt++;
      assert (retired_cnt_o === e.cnt) else begin
        n_fail++;
        $error("FAIL %s retired_cnt: got %0d expected %0d", e.tag, retired_cnt_o, e.cnt);
      end
    end
  end

  task automatic step(input string tag, input logic rst, input logic [6:0] op,
                      input logic [2:0] f3, input logic rdy, input logic [20:0] ev,
                      input bit retire);
    exp_t e;
    rst_i       = rst;
    opcode_i    = op;
    funct_3_i   = f3;
    mem_ready_i = rdy;
    e.tag = tag;
    e.vec = ev;
    e.cnt = (rst || !PerfEn) ? 4'd0 : exp_cnt;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (rst) exp_cnt = 4'd0;
    else if (retire) exp_cnt = exp_cnt + 4'd1;
  endtask

  // Four-cycle instructions: FETCH, DECODE, <exec>, ALU_WB.
  task automatic alu4(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [2:0] imm, input logic [20:0] ev);
    step({tag, "_fetch"}, 1'b0, op, f3, 1'b1, E_FR, 1'b0);
    step({tag, "_decode"}, 1'b0, op, f3, 1'b1, dec_ev(imm), 1'b0);
    step({tag, "_exec"}, 1'b0, op, f3, 1'b1, ev, 1'b0);
    step({tag, "_wb"}, 1'b0, op, f3, 1'b1, E_AWB, 1'b1);
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    step("reset0", 1'b1, 7'd0, 3'd0, 1'b1, E_ZERO, 1'b0);
    step("reset1", 1'b1, 7'd0, 3'd0, 1'b1, E_ZERO, 1'b0);

    alu4("add", 7'b0110011, 3'd0, 3'd0, E_EXR);

    step("lw_fetch", 1'b0, 7'b0000011, 3'd2, 1'b1, E_FR, 1'b0);
    step("lw_decode", 1'b0, 7'b0000011, 3'd2, 1'b1, dec_ev(3'd0), 1'b0);
    step("lw_adr", 1'b0, 7'b0000011, 3'd2, 1'b0, E_MADR, 1'b0);
    for (int i = 0; i < 3; i++) step("lw_wait", 1'b0, 7'b0000011, 3'd2, 1'b0, E_MRD, 1'b0);
    step("lw_rdy", 1'b0, 7'b0000011, 3'd2, 1'b1, E_MRD, 1'b0);
    step("lw_wb", 1'b0, 7'b0000011, 3'd2, 1'b0, E_MWB, 1'b1);

    step("jalr_fetch", 1'b0, 7'b1100111, 3'd0, 1'b1, E_FR, 1'b0);
    step("jalr_decode", 1'b0, 7'b1100111, 3'd0, 1'b1, dec_ev(3'd0), 1'b0);
    step("jalr", 1'b0, 7'b1100111, 3'd0, 1'b1, E_JALR, 1'b0);
    step("jalr_jmp", 1'b0, 7'b1100111, 3'd0, 1'b1, E_JMP, 1'b0);
    step("jalr_wb", 1'b0, 7'b1100111, 3'd0, 1'b1, E_AWB, 1'b1);

    alu4("lui", 7'b0110111, 3'd0, 3'd3, E_LUI);
    alu4("auipc", 7'b0010111, 3'd0, 3'd3, E_AUI);
    alu4("slli", 7'b0010011, 3'b001, 3'd5, E_EXI);
    alu4("srai", 7'b0010011, 3'b101, 3'd5, E_EXI);
    alu4("addi", 7'b0010011, 3'b000, 3'd0, E_EXI);
    alu4("jal", 7'b1101111, 3'd0, 3'd4, E_JMP);

    step("beq_fetch", 1'b0, 7'b1100011, 3'd0, 1'b1, E_FR, 1'b0);
    step("beq_decode", 1'b0, 7'b1100011, 3'd0, 1'b1, dec_ev(3'd2), 1'b0);
    step("beq", 1'b0, 7'b1100011, 3'd0, 1'b1, E_BR, 1'b1);

    // Fetch waits 15 cycles; ready on the 16th wait cycle completes without a trap.
    for (int i = 0; i < 15; i++) step("sw_fetch_wait", 1'b0, 7'b0100011, 3'd2, 1'b0, E_FW, 1'b0);
    step("sw_fetch_last", 1'b0, 7'b0100011, 3'd2, 1'b1, E_FR, 1'b0);
    step("sw_decode", 1'b0, 7'b0100011, 3'd2, 1'b0, dec_ev(3'd1), 1'b0);
    step("sw_adr", 1'b0, 7'b0100011, 3'd2, 1'b0, E_MADR, 1'b0);
    for (int i = 0; i < 16; i++) step("sw_wait", 1'b0, 7'b0100011, 3'd2, 1'b0, E_MWR, 1'b0);
    step("sw_timeout", 1'b0, 7'b0100011, 3'd2, 1'b0, trap_ev(2'd2), 1'b0);
    step("sw_trap_sticky", 1'b0, 7'b0110011, 3'd0, 1'b1, trap_ev(2'd2), 1'b0);
    step("sw_trap_rst", 1'b1, 7'b0110011, 3'd0, 1'b1, E_ZERO, 1'b0);
    step("after_rst_fetch", 1'b0, 7'b0110011, 3'd0, 1'b0, E_FW, 1'b0);

    for (int i = 0; i < 17; i++) alu4("wrap_add", 7'b0110011, 3'd0, 3'd0, E_EXR);

    step("ill_fetch", 1'b0, 7'b1111111, 3'd0, 1'b1, E_FR, 1'b0);
    step("ill_decode", 1'b0, 7'b1111111, 3'd0, 1'b1, dec_ev(3'd0), 1'b0);
    step("ill_trap", 1'b0, 7'b1111111, 3'd0, 1'b1, trap_ev(2'd1), 1'b0);
    step("ill_trap_sticky", 1'b0, 7'b0110011, 3'd0, 1'b1, trap_ev(2'd1), 1'b0);
    step("ill_rst", 1'b1, 7'b0110011, 3'd0, 1'b1, E_ZERO, 1'b0);

    step("lw2_fetch", 1'b0, 7'b0000011, 3'd2, 1'b1, E_FR, 1'b0);
    step("lw2_decode", 1'b0, 7'b0000011, 3'd2, 1'b1, dec_ev(3'd0), 1'b0);
    step("lw2_adr", 1'b0, 7'b0000011, 3'd2, 1'b0, E_MADR, 1'b0);
    step("lw2_wait", 1'b0, 7'b0000011, 3'd2, 1'b0, E_MRD, 1'b0);
    step("lw2_wait", 1'b0, 7'b0000011, 3'd2, 1'b0, E_MRD, 1'b0);
    step("lw2_mid_rst", 1'b1, 7'b0000011, 3'd2, 1'b0, E_ZERO, 1'b0);
    step("lw2_refetch", 1'b0, 7'b0000011, 3'd2, 1'b0, E_FW, 1'b0);

    @(negedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
